sync_filter_edge: RTL

//   Multi-channel clock-domain-crossing input conditioner: per channel, an N-flop

---
 rtl/sync_pkg.sv | 24 ++
 rtl/sync_filter_ch.sv | 90 +++++++++
 rtl/sync_filter_edge.sv | 33 +++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared constants and width helpers for the synchroniser/filter/edge-detect block.
package sync_pkg;

  localparam int   DEF_NUM_CH        = 4;
  localparam int   DEF_SYNC_STAGES   = 2;
  localparam int   DEF_FILTER_CYCLES = 4;
  localparam logic DEF_RESET_VAL     = 1'b0;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Stable-count width: holds 0..N-1, never narrower than one bit.
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: N-flop synchroniser, stable-count glitch filter, registered rise/fall pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic RESET_VAL     = DEF_RESET_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Plain shift chain: nothing between stages so only sync_q[0] can go metastable.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      // Bypass: dout tracks the synchronised level one edge later, pulses on any change.
      always_comb begin
        dout_d = s;
        rise_d = s & ~dout_q;
        fall_d = ~s & dout_q;
      end
    end else begin : g_filter
      localparam int            CW       = cnt_width(FILTER_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Qualifier: dout follows s only after FILTER_CYCLES consecutive mismatching edges.
      always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        dout_d = dout_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == dout_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          dout_d = s;
          cnt_d  = '0;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Mismatch counter; restarts from zero whenever s returns to dout.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Registered level and edge pulses; reset truncates any pulse in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel input conditioner: independent sync/filter/edge channels, no shared state.
module sync_filter_edge
  import sync_pkg::*;
#(
  parameter int   NUM_CH        = DEF_NUM_CH,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic RESET_VAL     = DEF_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .din (din[i]),
      .dout(dout[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

endmodule
